// File: rtl/bram_pixel_reader_pkg.sv
// Shared defaults and FSM encoding for the pixel BRAM read initiator.
// Pixels are {R,G,B}, taken from byte lanes {ram0,ram1,ram2}.
package bram_pixel_reader_pkg;

    localparam int DP_DEF = 512;
    localparam int DW_DEF = 24;
    localparam int FD_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bram_pixel_reader_if.sv
// Command, BRAM read-port and pixel-stream signals of the pixel reader.
// master = the reader itself, slave = the surrounding system.
interface bram_pixel_reader_if
    import bram_pixel_reader_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = $clog2(DP_DEF)
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [AW:0]     cmd_len;

    logic            mem_req;
    logic            mem_gnt;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW/8-1:0] mem_sel;
    logic [DW-1:0]   mem_rdata;

    logic            pix_valid;
    logic            pix_ready;
    logic [DW-1:0]   pix_data;
    logic            pix_last;

    logic            busy;
    logic            done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_gnt, mem_rdata, pix_ready,
        output cmd_ready, mem_req, mem_addr, mem_we, mem_sel,
               pix_valid, pix_data, pix_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_gnt, mem_rdata, pix_ready,
        input  cmd_ready, mem_req, mem_addr, mem_we, mem_sel,
               pix_valid, pix_data, pix_last, busy, done
    );
endinterface

// File: rtl/bram_pixel_reader_fifo.sv
// Small synchronous FIFO holding captured pixels plus their last-pixel tag.
// Output is read from storage only, so an entry is visible the cycle after its push.
module pix_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees the slot being written, so push is fine when full if popping too.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/bram_pixel_reader.sv
// Streams {base, length} pixel commands out of a shared, registered-read BRAM port.
// Reads are only issued while the FIFO has room for every read already in flight.
module bram_pixel_reader
    import bram_pixel_reader_pkg::*;
#(
    parameter int DP = DP_DEF,
    parameter int DW = DW_DEF,
    parameter int FD = FD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_pixel_reader_if.master   bus
);
    localparam int AW = $clog2(DP);
    localparam int CW = $clog2(FD) + 1;
    localparam logic [AW-1:0] ADDR_MAX = AW'(DP - 1);
    localparam logic [AW:0]   ONE_L    = (AW+1)'(1);
    localparam logic [CW:0]   FD_W     = (CW+1)'(FD);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued_q;
    logic          inflight_q;
    logic          inflight_last_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [DW:0]   fifo_dout;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          issue;
    logic          last_issue;
    logic          cmd_fire;
    logic          pop;
    logic [AW-1:0] addr_next;

    // Occupancy counts the read already on the BRAM pipeline as a used slot.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign credit_ok  = occupancy < FD_W;
    assign bus.mem_req = (state_q == ST_RUN) && (issued_q != len_q) && credit_ok;
    assign issue      = bus.mem_req && bus.mem_gnt;
    assign last_issue = issue && ((issued_q + ONE_L) == len_q);
    assign cmd_fire   = bus.cmd_valid && cmd_ready_q;
    assign pop        = bus.pix_valid && bus.pix_ready;
    assign addr_next  = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cmd_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= !cmd_fire;
                    if (cmd_fire) begin
                        addr_q   <= bus.cmd_addr;
                        len_q    <= bus.cmd_len;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_q   <= addr_next;
                        issued_q <= issued_q + ONE_L;
                    end
                    if (last_issue) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Empty FIFO with nothing in flight means the last pixel has left.
                    if (!inflight_q && fifo_empty) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pix_sync_fifo #(
        .DEPTH (FD),
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   ({inflight_last_q, bus.mem_rdata}),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_sel   = '0;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_dout[DW-1:0];
    assign bus.pix_last  = fifo_dout[DW] && !fifo_empty;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bram_pixel_reader.sv
// Bench for bram_pixel_reader: table of commands plus random commands against a
// word-level model of the BRAM contents and the expected pixel stream.
module tb_bram_pixel_reader;
    localparam int DP = 512;
    localparam int DW = 24;
    localparam int AW = 9;
    localparam int FD = 4;

    logic clk;
    logic rst;
    logic [DW-1:0] ram [DP];

    int n_vec;
    int n_bad;

    bram_pixel_reader_if #(.DW(DW), .AW(AW)) bus ();

    bram_pixel_reader #(.DP(DP), .DW(DW), .FD(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read BRAM behaviour: data for a granted read appears next cycle.
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt && !bus.mem_we)
            bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct {
        int          addr;
        int          len;
        int          gm;
        int          rm;
        logic [23:0] ef;
        logic [23:0] el;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input int mode, input int cyc);
        case (mode)
            0:       pick = 1'b1;
            1:       pick = 1'($urandom_range(0, 1));
            2:       pick = (cyc % 2) == 1;
            default: pick = (cyc % 3) == 0;
        endcase
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        chk({tag, "_mem_req"},   32'(bus.mem_req),   0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        chk({tag, "_pix_last"},  32'(bus.pix_last),  0);
        chk({tag, "_busy"},      32'(bus.busy),      0);
        chk({tag, "_done"},      32'(bus.done),      0);
    endtask

    task automatic run_cmd(input int addr, input int len, input int gm, input int rm,
                           input logic [23:0] ef, input logic [23:0] el);
        int iss, pops, cyc, waited, first_iss, first_val, last_xfer, done_cyc, budget;
        logic g, r;
        bit got_done;
        iss = 0; pops = 0; cyc = 0; waited = 0;
        first_iss = -1; first_val = -1; last_xfer = -1; done_cyc = -1;
        got_done = 0;
        budget = len * 8 + 40;

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = (AW+1)'(len);
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end

        while (!got_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            g = pick(gm, cyc);
            r = pick(rm, cyc);
            bus.mem_gnt   = g;
            bus.pix_ready = r;

            chk("credit_max", 32'((iss - pops) <= FD), 1);
            if (bus.mem_req) chk("req_needs_credit", 32'((iss - pops) < FD), 1);
            chk("busy_high", 32'(bus.busy), 1);
            chk("cmd_ready_low", 32'(bus.cmd_ready), 0);

            if (bus.mem_req) begin
                chk("read_in_range", 32'(iss < len), 1);
                chk(g ? "read_addr" : "denied_addr_hold", 32'(bus.mem_addr), 32'((addr + iss) % DP));
                if (g) begin
                    if (first_iss < 0) first_iss = cyc;
                    iss++;
                end
            end

            if (bus.pix_valid && first_val < 0) first_val = cyc;
            if (bus.pix_valid && r) begin
                chk("pixel_in_range", 32'(pops < len), 1);
                chk("pix_data", 32'(bus.pix_data), 32'(ram[(addr + pops) % DP]));
                chk("pix_last", 32'(bus.pix_last), 32'(pops == len - 1));
                if (pops == 0)       chk("first_pixel", 32'(bus.pix_data), 32'(ef));
                if (pops == len - 1) chk("last_pixel",  32'(bus.pix_data), 32'(el));
                pops++;
                last_xfer = cyc;
            end

            if (bus.done) begin
                got_done = 1;
                done_cyc = cyc;
                bus.cmd_valid = 1'b0;
            end else begin
                // Offer a different command while busy; it must not be taken.
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = AW'(addr + 37);
                bus.cmd_len   = (AW+1)'(3);
            end
        end

        chk("done_seen", 32'(got_done), 1);
        chk("pixel_count", 32'(pops), 32'(len));
        chk("read_count", 32'(iss), 32'(len));
        if (len > 0) chk("first_valid_latency", 32'(first_val - first_iss), 2);
        if (len == 0) chk("len0_done_soon", 32'(done_cyc >= 1 && done_cyc <= 2), 1);
        if (len > 0 && gm == 0 && rm == 0)
            chk("back_to_back", 32'(last_xfer - first_val), 32'(len - 1));

        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_done", 32'(bus.done), 0);
            chk("post_busy", 32'(bus.busy), 0);
            chk("post_mem_req", 32'(bus.mem_req), 0);
            chk("post_pix_valid", 32'(bus.pix_valid), 0);
            chk("post_cmd_ready", 32'(bus.cmd_ready), 1);
        end
        $display("cmd addr=%0d len=%0d gnt_mode=%0d rdy_mode=%0d pixels=%0d done_cycle=%0d",
                 addr, len, gm, rm, pops, done_cyc);
    endtask

    initial begin
        int pops, guard;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < DP; i++) ram[i] = 24'(i * 24'h010101);

        tbl[0] = '{addr: 0,   len: 8,   gm: 0, rm: 0, ef: 24'h000000, el: 24'h070707};
        tbl[1] = '{addr: 510, len: 4,   gm: 0, rm: 0, ef: 24'hFFFFFE, el: 24'h010101};
        tbl[2] = '{addr: 0,   len: 8,   gm: 0, rm: 3, ef: 24'h000000, el: 24'h070707};
        tbl[3] = '{addr: 0,   len: 8,   gm: 2, rm: 0, ef: 24'h000000, el: 24'h070707};
        tbl[4] = '{addr: 0,   len: 0,   gm: 0, rm: 0, ef: 24'h000000, el: 24'h000000};
        tbl[5] = '{addr: 508, len: 9,   gm: 1, rm: 1, ef: 24'hFDFDFC, el: 24'h040404};
        tbl[6] = '{addr: 100, len: 512, gm: 0, rm: 0, ef: 24'h646464, el: 24'h636363};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = '0;
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_mem_we", 32'(bus.mem_we), 0);
        chk("reset_mem_sel", 32'(bus.mem_sel), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.cmd_ready), 1);

        foreach (tbl[i])
            run_cmd(tbl[i].addr, tbl[i].len, tbl[i].gm, tbl[i].rm, tbl[i].ef, tbl[i].el);

        for (int i = 0; i < 12; i++) begin
            int a, l;
            a = int'($urandom_range(0, DP - 1));
            l = int'($urandom_range(0, 20));
            run_cmd(a, l, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ram[a], ram[(a + l + DP - 1) % DP]);
        end

        // Abort a command after three pixels.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = '0;
        bus.cmd_len   = (AW+1)'(8);
        bus.mem_gnt   = 1'b1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        pops = 0;
        guard = 0;
        while (pops < 3 && guard < 30) begin
            @(negedge clk);
            guard++;
            if (bus.pix_valid) pops++;
        end
        chk("abort_reached_3", 32'(pops), 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready_in_release", 32'(bus.cmd_ready), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 0);
            chk("abort_no_pix", 32'(bus.pix_valid), 0);
        end
        chk("abort_ready_again", 32'(bus.cmd_ready), 1);
        run_cmd(4, 2, 0, 0, 24'h040404, 24'h050505);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
